// File: rtl/br_tracker_alloc_arbiter.sv
// Round-robin arbiter sharing one freelist allocation port among several clients,
// with per-requester outstanding quotas and an owner table for dealloc crediting.
module br_tracker_alloc_arbiter #(
  parameter int unsigned NumRequesters  = 4,
  parameter int unsigned NumEntries     = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          OwnerCheckEn   = 1'b1,
  localparam int unsigned EntryIdWidth  = $clog2(NumEntries),
  localparam int unsigned CountWidth    = $clog2(MaxOutstanding + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         fl_alloc_valid,
  output logic                                         fl_alloc_ready,
  input  logic [EntryIdWidth-1:0]                      fl_alloc_entry_id,
  input  logic [NumRequesters-1:0]                     req_valid,
  output logic [NumRequesters-1:0]                     req_ready,
  output logic [EntryIdWidth-1:0]                      req_entry_id,
  input  logic [NumRequesters-1:0]                     req_dealloc_valid,
  input  logic [NumRequesters-1:0][EntryIdWidth-1:0]   req_dealloc_entry_id,
  output logic [NumRequesters-1:0]                     fl_dealloc_valid,
  output logic [NumRequesters-1:0][EntryIdWidth-1:0]   fl_dealloc_entry_id,
  output logic [NumRequesters-1:0][CountWidth-1:0]     outstanding_count,
  output logic                                         idle
);

  localparam int unsigned PtrWidth = $clog2(NumRequesters);
  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxOutstanding);

  logic [PtrWidth-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [NumRequesters-1:0][CountWidth-1:0]  count_q, count_d;
  logic [NumEntries-1:0]                     owner_valid_q, owner_valid_d;
  logic [PtrWidth-1:0]                       owner_q [NumEntries];
  logic [PtrWidth-1:0]                       owner_d [NumEntries];
  logic                                      idle_q, idle_d;

  logic [NumRequesters-1:0] eligible;
  logic                     any_eligible;
  logic                     grant;
  logic [PtrWidth-1:0]      winner;
  int unsigned              scan_idx;
  int                       dec_cnt [NumRequesters];
  int                       cnt_next;
  logic [NumRequesters-1:0] underflow;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      eligible[i] = req_valid[i] && (count_q[i] < MaxCount);
    end
  end

  // First eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    winner       = rr_ptr_q;
    any_eligible = 1'b0;
    scan_idx     = 0;
    for (int unsigned off = 0; off < NumRequesters; off++) begin
      scan_idx = (32'(rr_ptr_q) + off) % NumRequesters;
      if (!any_eligible && eligible[PtrWidth'(scan_idx)]) begin
        any_eligible = 1'b1;
        winner       = PtrWidth'(scan_idx);
      end
    end
  end

  assign grant          = fl_alloc_valid && any_eligible;
  assign fl_alloc_ready = grant;
  assign req_entry_id   = fl_alloc_entry_id;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign fl_dealloc_valid    = req_dealloc_valid;
  assign fl_dealloc_entry_id = req_dealloc_entry_id;

  // Owner-table and quota bookkeeping; deallocs credit owner[e], not the port index.
  always_comb begin
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    rr_ptr_d      = rr_ptr_q;
    count_d       = count_q;
    cnt_next      = 0;
    underflow     = '0;
    for (int r = 0; r < NumRequesters; r++) begin
      dec_cnt[r] = 0;
    end

    for (int i = 0; i < NumRequesters; i++) begin
      if (req_dealloc_valid[i] && (32'(req_dealloc_entry_id[i]) < NumEntries)) begin
        if (owner_valid_q[req_dealloc_entry_id[i]]) begin
          dec_cnt[owner_q[req_dealloc_entry_id[i]]] += 1;
        end
        owner_valid_d[req_dealloc_entry_id[i]] = 1'b0;
      end
    end

    if (grant) begin
      owner_d[fl_alloc_entry_id]       = winner;
      owner_valid_d[fl_alloc_entry_id] = 1'b1;
      rr_ptr_d = (32'(winner) == NumRequesters - 1) ? '0 : winner + 1'b1;
    end

    for (int r = 0; r < NumRequesters; r++) begin
      cnt_next = int'(count_q[r]) - dec_cnt[r];
      if (grant && (winner == PtrWidth'(r))) begin
        cnt_next = cnt_next + 1;
      end
      if (cnt_next < 0) begin
        underflow[r] = 1'b1;
        cnt_next     = 0;
      end
      count_d[r] = CountWidth'(cnt_next);
    end

    idle_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      count_q       <= '0;
      owner_valid_q <= '0;
      idle_q        <= 1'b1;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      count_q       <= count_d;
      owner_valid_q <= owner_valid_d;
      idle_q        <= idle_d;
    end
  end

  // Owner IDs are only meaningful where owner_valid is set, so no reset is needed.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
  end

  assign outstanding_count = count_q;
  assign idle              = idle_q;

  int cnt_sum;
  always_comb begin
    cnt_sum = 0;
    for (int r = 0; r < NumRequesters; r++) begin
      cnt_sum = cnt_sum + int'(count_q[r]);
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_count_sum: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_sum == $countones(owner_valid_q));
  a_grant_quota: assert property (@(posedge clk) disable iff (!rst_n)
    grant |-> (count_q[winner] < MaxCount));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    underflow == '0);

  for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_port_chk
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
    a_id_range: assert property (@(posedge clk) disable iff (!rst_n)
      req_dealloc_valid[gi] |-> (32'(req_dealloc_entry_id[gi]) < NumEntries));
    a_owner_match: assert property (@(posedge clk) disable iff (!rst_n)
      (OwnerCheckEn && req_dealloc_valid[gi] && (32'(req_dealloc_entry_id[gi]) < NumEntries))
      |-> (owner_valid_q[req_dealloc_entry_id[gi]] &&
           (owner_q[req_dealloc_entry_id[gi]] == PtrWidth'(gi))));
    a_no_alloc_dealloc_clash: assert property (@(posedge clk) disable iff (!rst_n)
      (grant && req_dealloc_valid[gi]) |-> (req_dealloc_entry_id[gi] != fl_alloc_entry_id));
  end

endmodule

// File: tb/tb_br_tracker_alloc_arbiter.sv
// Directed bench for br_tracker_alloc_arbiter: vector table plus hand sequences
// for quota stall, empty freelist, same-cycle grant/dealloc, multi-dealloc, reset.
module tb_br_tracker_alloc_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned NE = 8;
  localparam int unsigned MO = 4;
  localparam int unsigned EW = 3;
  localparam int unsigned CW = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    fl_alloc_valid;
  logic                    fl_alloc_ready;
  logic [EW-1:0]           fl_alloc_entry_id;
  logic [NR-1:0]           req_valid;
  logic [NR-1:0]           req_ready;
  logic [EW-1:0]           req_entry_id;
  logic [NR-1:0]           req_dealloc_valid;
  logic [NR-1:0][EW-1:0]   req_dealloc_entry_id;
  logic [NR-1:0]           fl_dealloc_valid;
  logic [NR-1:0][EW-1:0]   fl_dealloc_entry_id;
  logic [NR-1:0][CW-1:0]   outstanding_count;
  logic                    idle;

  int checks = 0;
  int failures = 0;

  br_tracker_alloc_arbiter #(
    .NumRequesters (NR),
    .NumEntries    (NE),
    .MaxOutstanding(MO),
    .OwnerCheckEn  (1'b0)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fl_alloc_valid      (fl_alloc_valid),
    .fl_alloc_ready      (fl_alloc_ready),
    .fl_alloc_entry_id   (fl_alloc_entry_id),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_entry_id        (req_entry_id),
    .req_dealloc_valid   (req_dealloc_valid),
    .req_dealloc_entry_id(req_dealloc_entry_id),
    .fl_dealloc_valid    (fl_dealloc_valid),
    .fl_dealloc_entry_id (fl_dealloc_entry_id),
    .outstanding_count   (outstanding_count),
    .idle                (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic        fav;
    logic [2:0]  fid;
    logic [3:0]  dv;
    logic [11:0] did;
    logic [3:0]  exp_rdy;
    logic        exp_far;
    logic [11:0] exp_cnt;
    logic        exp_idle;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rv, input logic fav, input logic [2:0] fid,
                       input logic [3:0] dv, input logic [11:0] did);
    req_valid            = rv;
    fl_alloc_valid       = fav;
    fl_alloc_entry_id    = fid;
    req_dealloc_valid    = dv;
    req_dealloc_entry_id = did;
  endtask

  // Entered just after a rising edge; checks combinational outputs mid-cycle, state after the edge.
  task automatic do_cycle(input string tag, input logic [3:0] erdy, input logic efar,
                          input logic [11:0] ecnt, input logic eidle);
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(erdy));
    chk({tag, "_fl_alloc_ready"}, 32'(fl_alloc_ready), 32'(efar));
    chk({tag, "_fl_dealloc_valid"}, 32'(fl_dealloc_valid), 32'(req_dealloc_valid));
    chk({tag, "_fl_dealloc_id"}, 32'(fl_dealloc_entry_id), 32'(req_dealloc_entry_id));
    if (efar) chk({tag, "_req_entry_id"}, 32'(req_entry_id), 32'(fl_alloc_entry_id));
    @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(outstanding_count), 32'(ecnt));
    chk({tag, "_idle"}, 32'(idle), 32'(eidle));
  endtask

  initial begin
    // Round robin across all four, second lap, then release everything.
    vecs[0]  = '{4'b1111, 1'b1, 3'd0, 4'b0000, 12'h000, 4'b0001, 1'b1, 12'h001, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 3'd1, 4'b0000, 12'h000, 4'b0010, 1'b1, 12'h009, 1'b0};
    vecs[2]  = '{4'b1111, 1'b1, 3'd2, 4'b0000, 12'h000, 4'b0100, 1'b1, 12'h049, 1'b0};
    vecs[3]  = '{4'b1111, 1'b1, 3'd3, 4'b0000, 12'h000, 4'b1000, 1'b1, 12'h249, 1'b0};
    vecs[4]  = '{4'b1111, 1'b1, 3'd4, 4'b0000, 12'h000, 4'b0001, 1'b1, 12'h24A, 1'b0};
    vecs[5]  = '{4'b1110, 1'b0, 3'd5, 4'b0000, 12'h000, 4'b0000, 1'b0, 12'h24A, 1'b0};
    vecs[6]  = '{4'b1110, 1'b1, 3'd5, 4'b0000, 12'h000, 4'b0010, 1'b1, 12'h252, 1'b0};
    vecs[7]  = '{4'b1100, 1'b1, 3'd6, 4'b0000, 12'h000, 4'b0100, 1'b1, 12'h292, 1'b0};
    vecs[8]  = '{4'b1000, 1'b1, 3'd7, 4'b0000, 12'h000, 4'b1000, 1'b1, 12'h492, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 3'd0, 4'b1111, 12'h688, 4'b0000, 1'b0, 12'h249, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 3'd0, 4'b1111, 12'hFAC, 4'b0000, 1'b0, 12'h000, 1'b1};

    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 3'd0, 4'b0000, 12'h000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(outstanding_count), 32'h0);
    chk("reset_idle", 32'(idle), 32'h1);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_fl_alloc_ready", 32'(fl_alloc_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rv, vecs[i].fav, vecs[i].fid, vecs[i].dv, vecs[i].did);
      do_cycle($sformatf("rr_v%0d", i), vecs[i].exp_rdy, vecs[i].exp_far,
               vecs[i].exp_cnt, vecs[i].exp_idle);
    end

    // Quota stall: requester 2 fills its quota of 4, stalls, regains eligibility after a dealloc.
    drive(4'b0100, 1'b1, 3'd0, 4'b0000, 12'h000); do_cycle("q_g0", 4'b0100, 1'b1, 12'h040, 1'b0);
    drive(4'b0100, 1'b1, 3'd1, 4'b0000, 12'h000); do_cycle("q_g1", 4'b0100, 1'b1, 12'h080, 1'b0);
    drive(4'b0100, 1'b1, 3'd2, 4'b0000, 12'h000); do_cycle("q_g2", 4'b0100, 1'b1, 12'h0C0, 1'b0);
    drive(4'b0100, 1'b1, 3'd3, 4'b0000, 12'h000); do_cycle("q_g3", 4'b0100, 1'b1, 12'h100, 1'b0);
    drive(4'b0100, 1'b1, 3'd4, 4'b0000, 12'h000); do_cycle("q_stall0", 4'b0000, 1'b0, 12'h100, 1'b0);
    drive(4'b0100, 1'b1, 3'd4, 4'b0000, 12'h000); do_cycle("q_stall1", 4'b0000, 1'b0, 12'h100, 1'b0);
    drive(4'b0100, 1'b1, 3'd4, 4'b0100, 12'h040); do_cycle("q_dealloc_t", 4'b0000, 1'b0, 12'h0C0, 1'b0);
    drive(4'b0100, 1'b1, 3'd4, 4'b0000, 12'h000); do_cycle("q_regrant", 4'b0100, 1'b1, 12'h100, 1'b0);
    drive(4'b0000, 1'b0, 3'd0, 4'b0100, 12'h000); do_cycle("q_free0", 4'b0000, 1'b0, 12'h0C0, 1'b0);
    drive(4'b0000, 1'b0, 3'd0, 4'b0100, 12'h080); do_cycle("q_free2", 4'b0000, 1'b0, 12'h080, 1'b0);
    drive(4'b0000, 1'b0, 3'd0, 4'b0100, 12'h0C0); do_cycle("q_free3", 4'b0000, 1'b0, 12'h040, 1'b0);
    drive(4'b0000, 1'b0, 3'd0, 4'b0100, 12'h100); do_cycle("q_free4", 4'b0000, 1'b0, 12'h000, 1'b1);

    // Empty freelist: nobody granted and rr_ptr (now 3) holds across the stall.
    for (int c = 0; c < 10; c++) begin
      drive(4'b1111, 1'b0, 3'd0, 4'b0000, 12'h000);
      do_cycle($sformatf("empty_c%0d", c), 4'b0000, 1'b0, 12'h000, 1'b1);
    end
    drive(4'b1111, 1'b1, 3'd0, 4'b0000, 12'h000); do_cycle("empty_first", 4'b1000, 1'b1, 12'h200, 1'b0);
    drive(4'b0111, 1'b1, 3'd1, 4'b0000, 12'h000); do_cycle("empty_r0", 4'b0001, 1'b1, 12'h201, 1'b0);
    drive(4'b0110, 1'b1, 3'd2, 4'b0000, 12'h000); do_cycle("empty_r1", 4'b0010, 1'b1, 12'h209, 1'b0);
    drive(4'b0100, 1'b1, 3'd3, 4'b0000, 12'h000); do_cycle("empty_r2", 4'b0100, 1'b1, 12'h249, 1'b0);

    // Requester 1 (holding ID 2) is granted ID 4 and frees ID 2 in the same cycle.
    drive(4'b0010, 1'b1, 3'd4, 4'b0010, 12'h010); do_cycle("simul", 4'b0010, 1'b1, 12'h249, 1'b0);
    chk("simul_owner_valid", 32'(dut.owner_valid_q), 32'h1B);
    drive(4'b0000, 1'b0, 3'd0, 4'b1111, 12'h0E1); do_cycle("simul_clean", 4'b0000, 1'b0, 12'h000, 1'b1);
    chk("simul_clean_owner_valid", 32'(dut.owner_valid_q), 32'h00);

    // Requester 0 holds 0,1,2; ports 0 and 3 free 0 and 2 together, both credited to requester 0.
    drive(4'b0001, 1'b1, 3'd0, 4'b0000, 12'h000); do_cycle("md_g0", 4'b0001, 1'b1, 12'h001, 1'b0);
    drive(4'b0001, 1'b1, 3'd1, 4'b0000, 12'h000); do_cycle("md_g1", 4'b0001, 1'b1, 12'h002, 1'b0);
    drive(4'b0001, 1'b1, 3'd2, 4'b0000, 12'h000); do_cycle("md_g2", 4'b0001, 1'b1, 12'h003, 1'b0);
    drive(4'b0000, 1'b0, 3'd0, 4'b1001, 12'h400); do_cycle("md_multi", 4'b0000, 1'b0, 12'h001, 1'b0);
    chk("md_owner_valid", 32'(dut.owner_valid_q), 32'h02);
    drive(4'b0000, 1'b0, 3'd0, 4'b0001, 12'h001); do_cycle("md_last", 4'b0000, 1'b0, 12'h000, 1'b1);

    // Reset with three entries outstanding drops all state.
    drive(4'b0010, 1'b1, 3'd0, 4'b0000, 12'h000); do_cycle("rst_g0", 4'b0010, 1'b1, 12'h008, 1'b0);
    drive(4'b0010, 1'b1, 3'd1, 4'b0000, 12'h000); do_cycle("rst_g1", 4'b0010, 1'b1, 12'h010, 1'b0);
    drive(4'b0010, 1'b1, 3'd2, 4'b0000, 12'h000); do_cycle("rst_g2", 4'b0010, 1'b1, 12'h018, 1'b0);
    drive(4'b0000, 1'b0, 3'd0, 4'b0000, 12'h000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_count", 32'(outstanding_count), 32'h0);
    chk("midrst_idle", 32'(idle), 32'h1);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_owner_valid", 32'(dut.owner_valid_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(4'b1111, 1'b1, 3'd5, 4'b0000, 12'h000); do_cycle("postrst_ptr0", 4'b0001, 1'b1, 12'h001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
